// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, opcodes and default widths for the SPI slave front end.
package spi_pkg;
   localparam int FRAME_W_DEF = 10;
   localparam int DATA_W_DEF  = 8;
   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;
   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
   function automatic logic is_shift_state(input state_t s);
      return s inside {WRITE, READ_ADD, READ_DATA};
   endfunction
endpackage

// File: rtl/spi_miso_serializer.sv
// spi_miso_serializer: captures RAM read data on load and shifts it out MSB first;
// done is high during the clock in which the last bit is on the wire.
module spi_miso_serializer
   import spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              miso,
   output logic              busy,
   output logic              done
);
   localparam int CW = $clog2(DATA_W);
   logic [DATA_W-1:0] sh;
   logic [CW-1:0] cnt;
   assign done = busy && cnt == '0;
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         miso <= 1'b0;
         busy <= 1'b0;
         sh   <= '0;
         cnt  <= '0;
      end else if (clear) begin
         miso <= 1'b0;
         busy <= 1'b0;
         cnt  <= '0;
      end else if (load) begin
         miso <= data[DATA_W-1];
         sh   <= data << 1;
         cnt  <= CW'(DATA_W - 1);
         busy <= 1'b1;
      end else if (busy) begin
         miso <= done ? 1'b0 : sh[DATA_W-1];
         sh   <= sh << 1;
         cnt  <= done ? '0 : cnt - CW'(1);
         busy <= !done;
      end
   end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: deserialises MOSI frames into RAM command words and serialises RAM read data onto MISO.
// Define SPI_SLAVE_FRAME_ERR_EN to add the frame_err abort pulse output.
module spi_slave
   import spi_pkg::*;
#(
   parameter int FRAME_W = FRAME_W_DEF,
   parameter int DATA_W  = DATA_W_DEF
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               SS_n,
   input  logic               MOSI,
   output logic               MISO,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   input  logic [DATA_W-1:0]  tx_data,
   input  logic               tx_valid
`ifdef SPI_SLAVE_FRAME_ERR_EN
   ,output logic              frame_err
`endif
);
   localparam int CW = $clog2(FRAME_W);
   state_t state, next;
   logic [CW-1:0] cnt;
   logic rd_addr_seen, rcv_done, tx_done, ser_busy, ser_done, shift_in, last_bit, load;
   assign shift_in = !SS_n && (state == CHK_CMD || (is_shift_state(state) && !rcv_done));
   assign last_bit = shift_in && state != CHK_CMD && cnt == CW'(FRAME_W - 2);
   assign load     = !SS_n && state == READ_DATA && rcv_done && !ser_busy && !tx_done && tx_valid;
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state;
      next = SS_n ? IDLE :
             state == IDLE ? CHK_CMD :
             state == CHK_CMD ? (!MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD) :
             state;
   end
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt          <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rd_addr_seen <= 1'b0;
         rcv_done     <= 1'b0;
         tx_done      <= 1'b0;
      end else begin
         rx_valid <= last_bit;
         if (shift_in) rx_data <= {rx_data[FRAME_W-2:0], MOSI};
         cnt      <= (SS_n || last_bit) ? '0 : (shift_in && state != CHK_CMD) ? cnt + CW'(1) : cnt;
         rcv_done <= !SS_n && (rcv_done || last_bit);
         tx_done  <= !SS_n && (tx_done || ser_done);
         // a completed MISO shift consumes the pending read address
         if (ser_done) rd_addr_seen <= 1'b0;
         else if (last_bit && state == READ_ADD) rd_addr_seen <= 1'b1;
      end
   end
   spi_miso_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk    (clk),
      .arst_n (arst_n),
      .clear  (SS_n),
      .load   (load),
      .data   (tx_data),
      .miso   (MISO),
      .busy   (ser_busy),
      .done   (ser_done)
   );
`ifdef SPI_SLAVE_FRAME_ERR_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) frame_err <= 1'b0;
      else frame_err <= SS_n && state != IDLE &&
                        !(rcv_done && (state != READ_DATA || tx_done || ser_done));
   end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed frames push expected rx words, MISO bits and abort pulses into
// queues stamped with the clock edge; a monitor pops and compares them as the DUT responds.
module tb_spi_slave;
   logic clk = 1'b0, arst_n = 1'b1, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic MISO, rx_valid;
   logic [9:0] rx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic frame_err;
`endif
   int cyc = 0, checks = 0, errors = 0;
   bit rd_seen = 1'b0;
   typedef struct {int cyc; int val;} exp_t;
   exp_t rx_q[$], miso_q[$], err_q[$];

   spi_slave dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
`ifdef SPI_SLAVE_FRAME_ERR_EN
      ,.frame_err(frame_err)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (rx_valid) begin
         if (rx_q.size() == 0) check("rx_valid_spurious", rx_valid, 0);
         else begin
            e = rx_q.pop_front();
            check("rx_valid_cycle", cyc, e.cyc);
            check("rx_data", rx_data, e.val);
         end
      end else if (rx_q.size() > 0 && rx_q[0].cyc <= cyc) begin
         e = rx_q.pop_front();
         check("rx_valid", rx_valid, 1);
      end
      while (miso_q.size() > 0 && miso_q[0].cyc <= cyc) begin
         e = miso_q.pop_front();
         check("miso", MISO, e.val);
      end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) begin
         if (err_q.size() == 0) check("frame_err_spurious", frame_err, 0);
         else begin
            e = err_q.pop_front();
            check("frame_err_cycle", cyc, e.cyc);
         end
      end else if (err_q.size() > 0 && err_q[0].cyc <= cyc) begin
         e = err_q.pop_front();
         check("frame_err", frame_err, 1);
      end
`endif
   end

   // stop: offset from the select edge at which SS_n is raised (21 = full frame); rst asserts arst_n instead
   task automatic frame(input logic [9:0] bits, input logic [7:0] tx, input int stop, input bit rst);
      int e0;
      bit sh;
      @(negedge clk);
      e0 = cyc + 1;
      sh = bits[9] && rd_seen;
      SS_n = 1'b0;
      MOSI = 1'b0;
      tx_data = tx;
      if (stop >= 10) rx_q.push_back('{e0 + 10, int'(bits)});
      for (int k = 11; k <= stop; k++)
         miso_q.push_back('{e0 + k, (sh && k >= 12 && k <= 19) ? int'(tx[19 - k]) : 0});
      miso_q.push_back('{e0 + stop + 1, 0});
      if (!rst && (stop < 10 || (sh && stop < 20))) err_q.push_back('{e0 + stop + 1, 1});
      if (rst) rd_seen = 1'b0;
      else if (stop >= 10 && bits[9] && !rd_seen) rd_seen = 1'b1;
      else if (sh && stop >= 20) rd_seen = 1'b0;
      for (int k = 0; k <= stop; k++) begin
         @(negedge clk);
         MOSI = (k <= 9) ? bits[9 - k] : 1'b0;
         tx_valid = (k == 11);
         if (k == stop) begin
            SS_n = 1'b1;
            MOSI = 1'b0;
            tx_valid = 1'b0;
            if (rst) begin
               arst_n = 1'b0;
               #1;
               check("rst_miso", MISO, 0);
               check("rst_rx_valid", rx_valid, 0);
               check("rst_rx_data", rx_data, 0);
            end
         end
      end
      @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1 arst_n = 1'b0;
      #2;
      check("reset_miso", MISO, 0);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      repeat (3) @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      frame(10'h0A5, 8'h55, 21, 0);
      frame(10'h13C, 8'hFF, 21, 0);
      frame(10'h2A5, 8'hFF, 21, 0);
      frame(10'h300, 8'h3C, 21, 0);
      frame(10'h2F0, 8'h0F, 21, 0);
      frame(10'h1AA, 8'hF0, 21, 0);
      frame(10'h3FF, 8'hA5, 21, 0);
      frame(10'h155, 8'h00, 5, 0);
      frame(10'h2AA, 8'hFF, 5, 0);
      frame(10'h3FF, 8'hC3, 21, 0);
      frame(10'h300, 8'h96, 15, 0);
      frame(10'h300, 8'h69, 21, 0);
      frame(10'h0FF, 8'h00, 9, 0);
      frame(10'h0F0, 8'h00, 10, 0);
      frame(10'h211, 8'h00, 21, 0);
      frame(10'h3AB, 8'hE7, 16, 1);
      frame(10'h3AB, 8'h81, 21, 0);
      frame(10'h300, 8'h81, 21, 0);
      repeat (3) @(negedge clk);
      check("rx_q_drained", rx_q.size(), 0);
      check("miso_q_drained", miso_q.size(), 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("err_q_drained", err_q.size(), 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
